// File: rtl/gpio_pkg.sv
// Shared encodings for the GPIO function-select controller.
package gpio_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic FN_GPIO = 1'b0;
    localparam logic FN_ALT  = 1'b1;

endpackage

// File: rtl/lowest_set_idx.sv
// Combinational priority encoder: index of the lowest set bit plus a valid flag.
module lowest_set_idx #(
    parameter int unsigned W  = 16,
    parameter int unsigned IW = 4
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_mux_ctrl.sv
// Glitch-free select sequencer for the 2:1 pin muxes: flips one select at a
// time, only when both mux inputs agree, or after a bounded wait.
module gpio_mux_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned PINS    = 16,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TW      = 10
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cfg_we,
    input  logic [PINS-1:0] cfg_mode,
    input  logic [PINS-1:0] gpio_out,
    input  logic [PINS-1:0] alt_out,
    output logic [PINS-1:0] mux_sel,
    output logic            busy,
    output logic            done,
    output logic            forced,
    output logic [PINS-1:0] target
);

    localparam int unsigned   IW       = (PINS > 1) ? $clog2(PINS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   tmo_cnt;
    logic [PINS-1:0] pending;
    logic [PINS-1:0] target_nxt;
    logic [PINS-1:0] mux_sel_nxt;
    logic [IW-1:0]   scan_idx;
    logic            scan_valid;
    logic            cancel_c;
    logic            lvl_match_c;
    logic            tmo_hit_c;
    logic            commit_c;

    assign pending = target ^ mux_sel;
    assign busy    = |pending;

    lowest_set_idx #(
        .W  (PINS),
        .IW (IW)
    ) u_scan (
        .vec   (pending),
        .idx   (scan_idx),
        .valid (scan_valid)
    );

    // Per-pin decision terms for the pin under service, and next register values.
    always_comb begin
        cancel_c    = (target[idx] == mux_sel[idx]);
        lvl_match_c = (gpio_out[idx] == alt_out[idx]);
        tmo_hit_c   = (tmo_cnt == TMO_LAST);
        commit_c    = (state == ST_WAIT) && !cancel_c && (lvl_match_c || tmo_hit_c);
        target_nxt  = cfg_we ? cfg_mode : target;
        mux_sel_nxt = mux_sel;
        if (commit_c) begin
            mux_sel_nxt[idx] = target[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            idx     <= '0;
            tmo_cnt <= '0;
            target  <= {PINS{FN_GPIO}};
            mux_sel <= {PINS{FN_GPIO}};
            done    <= 1'b0;
            forced  <= 1'b0;
        end else begin
            target  <= target_nxt;
            mux_sel <= mux_sel_nxt;
            // Pending emptied on this edge, whether by commit or by a rewrite.
            done    <= busy && ((target_nxt ^ mux_sel_nxt) == '0);
            forced  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (scan_valid) begin
                        idx     <= scan_idx;
                        tmo_cnt <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cancel_c || commit_c) begin
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                    forced <= commit_c && !lvl_match_c;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_mux_ctrl.sv
// Self-checking bench for gpio_mux_ctrl: directed scenarios plus a randomized run
// against a behavioural model.
module tb_gpio_mux_ctrl;

    localparam int unsigned PINS    = 16;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TW      = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            cfg_we;
    logic [PINS-1:0] cfg_mode;
    logic [PINS-1:0] gpio_out;
    logic [PINS-1:0] alt_out;
    logic [PINS-1:0] mux_sel;
    logic            busy;
    logic            done;
    logic            forced;
    logic [PINS-1:0] target;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [PINS-1:0] m_target;
    logic [PINS-1:0] m_sel;
    logic            m_done;
    logic            m_forced;
    int              m_svc;
    int              m_cnt;

    gpio_mux_ctrl #(
        .PINS    (PINS),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .cfg_we   (cfg_we),
        .cfg_mode (cfg_mode),
        .gpio_out (gpio_out),
        .alt_out  (alt_out),
        .mux_sel  (mux_sel),
        .busy     (busy),
        .done     (done),
        .forced   (forced),
        .target   (target)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        cfg_we = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    function automatic int lowest_pin(input logic [PINS-1:0] v);
        for (int i = 0; i < int'(PINS); i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock edge of the reference behaviour, using the inputs present at that edge.
    task automatic model_step();
        logic [PINS-1:0] old_pend;
        logic [PINS-1:0] new_target;
        logic [PINS-1:0] new_sel;
        if (!resetn) begin
            m_target = '0;
            m_sel    = '0;
            m_done   = 1'b0;
            m_forced = 1'b0;
            m_svc    = -1;
            m_cnt    = 0;
        end else begin
            old_pend   = m_target ^ m_sel;
            new_target = cfg_we ? cfg_mode : m_target;
            new_sel    = m_sel;
            m_forced   = 1'b0;
            if (m_svc < 0) begin
                if (old_pend != '0) begin
                    m_svc = lowest_pin(old_pend);
                    m_cnt = 0;
                end
            end else if (m_target[m_svc] == m_sel[m_svc]) begin
                m_svc = -1;
            end else if (gpio_out[m_svc] == alt_out[m_svc]) begin
                new_sel[m_svc] = m_target[m_svc];
                m_svc = -1;
            end else if (m_cnt == int'(TIMEOUT) - 1) begin
                new_sel[m_svc] = m_target[m_svc];
                m_forced = 1'b1;
                m_svc = -1;
            end else begin
                m_cnt++;
            end
            m_done   = (old_pend != '0) && ((new_target ^ new_sel) == '0);
            m_target = new_target;
            m_sel    = new_sel;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cfg_we   = 1'($urandom);
            cfg_mode = PINS'($urandom);
            gpio_out = PINS'($urandom);
            alt_out  = PINS'($urandom);
            cyc();
        end
        n_cmp++;
        if (mux_sel !== '0) begin n_err++; $display("FAIL reset_mux_sel: got %h expected 0", mux_sel); end
        n_cmp++;
        if (target !== '0) begin n_err++; $display("FAIL reset_target: got %h expected 0", target); end
        n_cmp++;
        if ({busy, done, forced} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got busy/done/forced=%b expected 000", {busy, done, forced});
        end
        resetn = 1'b1;
        cfg_we = 1'b0;
    endtask

    task automatic test_matched();
        int dones = 0;
        int forces = 0;
        apply_reset();
        gpio_out = '0;
        alt_out  = '0;
        cfg_mode = 16'h0001;
        cfg_we   = 1'b1;
        cyc();
        cfg_we = 1'b0;
        n_cmp++;
        if (target !== 16'h0001 || busy !== 1'b1) begin
            n_err++; $display("FAIL matched_target: got target=%h busy=%b expected 0001/1", target, busy);
        end
        for (int j = 1; j <= 5; j++) begin
            cyc();
            dones += int'(done);
            forces += int'(forced);
            if (j == 1) begin
                n_cmp++;
                if (mux_sel !== 16'h0000) begin n_err++; $display("FAIL matched_early: got %h expected 0000", mux_sel); end
            end
            if (j == 2) begin
                n_cmp++;
                if (mux_sel !== 16'h0001) begin n_err++; $display("FAIL matched_sel: got %h expected 0001", mux_sel); end
                n_cmp++;
                if (done !== 1'b1) begin n_err++; $display("FAIL matched_done: got %b expected 1", done); end
            end
        end
        n_cmp++;
        if (dones != 1 || forces != 0) begin
            n_err++; $display("FAIL matched_pulses: got done=%0d forced=%0d expected 1/0", dones, forces);
        end
    endtask

    task automatic test_forced();
        int forces = 0;
        apply_reset();
        gpio_out = 16'h0008;
        alt_out  = 16'h0000;
        cfg_mode = 16'h0008;
        cfg_we   = 1'b1;
        cyc();
        cfg_we = 1'b0;
        for (int j = 1; j <= int'(TIMEOUT) + 3; j++) begin
            cyc();
            forces += int'(forced);
            if (j == int'(TIMEOUT)) begin
                n_cmp++;
                if (mux_sel !== 16'h0000) begin n_err++; $display("FAIL forced_early: got %h expected 0000", mux_sel); end
            end
            if (j == int'(TIMEOUT) + 1) begin
                n_cmp++;
                if (mux_sel !== 16'h0008) begin n_err++; $display("FAIL forced_sel: got %h expected 0008", mux_sel); end
                n_cmp++;
                if (forced !== 1'b1) begin n_err++; $display("FAIL forced_flag: got %b expected 1", forced); end
            end
        end
        n_cmp++;
        if (forces != 1) begin n_err++; $display("FAIL forced_count: got %0d expected 1", forces); end
    endtask

    task automatic test_delayed_match();
        int forces = 0;
        apply_reset();
        gpio_out = 16'h0004;
        alt_out  = 16'h0000;
        cfg_mode = 16'h0004;
        cfg_we   = 1'b1;
        cyc();
        cfg_we = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            forces += int'(forced);
        end
        n_cmp++;
        if (mux_sel !== 16'h0000) begin n_err++; $display("FAIL delayed_hold: got %h expected 0000", mux_sel); end
        alt_out = 16'h0004;
        cyc();
        forces += int'(forced);
        n_cmp++;
        if (mux_sel !== 16'h0004) begin n_err++; $display("FAIL delayed_sel: got %h expected 0004", mux_sel); end
        cyc();
        forces += int'(forced);
        n_cmp++;
        if (forces != 0) begin n_err++; $display("FAIL delayed_forced: got %0d expected 0", forces); end
    endtask

    task automatic test_multi_pin();
        logic [PINS-1:0] exp_sel;
        apply_reset();
        gpio_out = '0;
        alt_out  = '0;
        cfg_mode = 16'h8011;
        cfg_we   = 1'b1;
        cyc();
        cfg_we = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            cyc();
            exp_sel = (j >= 6) ? 16'h8011 : (j >= 4) ? 16'h0011 : (j >= 2) ? 16'h0001 : 16'h0000;
            n_cmp++;
            if (mux_sel !== exp_sel || done !== 1'(j == 6)) begin
                n_err++;
                $display("FAIL multi_cycle%0d: got sel=%h done=%b expected sel=%h done=%b",
                         j, mux_sel, done, exp_sel, 1'(j == 6));
            end
        end
    endtask

    task automatic test_cancel();
        int dones = 0;
        int forces = 0;
        int sel_bad = 0;
        apply_reset();
        gpio_out = 16'h0020;
        alt_out  = 16'h0000;
        cfg_mode = 16'h0020;
        cfg_we   = 1'b1;
        cyc();
        cfg_we = 1'b0;
        for (int j = 0; j < 3; j++) cyc();
        cfg_mode = 16'h0000;
        cfg_we   = 1'b1;
        cyc();
        cfg_we = 1'b0;
        dones += int'(done);
        for (int j = 0; j < int'(TIMEOUT) + 4; j++) begin
            cyc();
            dones += int'(done);
            forces += int'(forced);
            if (mux_sel !== '0) sel_bad++;
        end
        n_cmp++;
        if (sel_bad != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL cancel_sel: got %0d bad cycles busy=%b expected 0/0", sel_bad, busy);
        end
        n_cmp++;
        if (dones != 1 || forces != 0) begin
            n_err++; $display("FAIL cancel_pulses: got done=%0d forced=%0d expected 1/0", dones, forces);
        end

        // Reset landing in the middle of a wait
        cfg_mode = 16'h0020;
        cfg_we   = 1'b1;
        cyc();
        cfg_we = 1'b0;
        for (int j = 0; j < 3; j++) cyc();
        resetn = 1'b0;
        cyc();
        n_cmp++;
        if (mux_sel !== '0 || target !== '0 || {busy, done, forced} !== 3'b000) begin
            n_err++;
            $display("FAIL midwait_reset: got sel=%h tgt=%h flags=%b expected 0/0/000",
                     mux_sel, target, {busy, done, forced});
        end
        resetn = 1'b1;
        for (int j = 0; j < int'(TIMEOUT) + 3; j++) cyc();
        n_cmp++;
        if (mux_sel !== '0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midwait_after: got sel=%h busy=%b expected 0/0", mux_sel, busy);
        end
    endtask

    task automatic test_random();
        logic [PINS-1:0] diff;
        logic [PINS+PINS+3-1:0] got;
        logic [PINS+PINS+3-1:0] exp;
        int hold = 0;
        diff = '0;
        resetn = 1'b0;
        cfg_we = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        resetn = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                diff = PINS'($urandom) & PINS'($urandom) & PINS'($urandom);
                hold = int'($urandom_range(4, 20));
            end
            hold--;
            resetn   = ($urandom_range(0, 299) != 0);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_mode = PINS'($urandom) & PINS'($urandom);
            gpio_out = PINS'($urandom);
            alt_out  = gpio_out ^ diff;
            @(posedge clk);
            model_step();
            #1;
            got = {mux_sel, target, busy, done, forced};
            exp = {m_sel, m_target, 1'((m_target ^ m_sel) != '0), m_done, m_forced};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random_cycle%0d: got sel=%h tgt=%h b/d/f=%b expected sel=%h tgt=%h b/d/f=%b",
                         c, mux_sel, target, {busy, done, forced},
                         m_sel, m_target, exp[2:0]);
            end
        end
        resetn = 1'b1;
        cfg_we = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        cfg_we   = 1'b0;
        cfg_mode = '0;
        gpio_out = '0;
        alt_out  = '0;
        #1;
        test_reset();
        test_matched();
        test_forced();
        test_delayed_match();
        test_multi_pin();
        test_cancel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
